// File: rtl/counter_load_checker.sv
// rtl/counter_load_checker.sv - predicts each next value of a loadable mod-(MAX_VAL+1) counter and flags deviations
// Tracks lock status, emits a one-cycle error pulse and keeps a saturating error count.
module counter_load_checker #(
  parameter int WIDTH        = 4,
  parameter int MAX_VAL      = 13,
  parameter int LOCK_MATCHES = 2,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 err_clr_i,
  input  logic                 load_i,
  input  logic [WIDTH-1:0]     data_in_i,
  input  logic [WIDTH-1:0]     count_in_i,
  output logic [WIDTH-1:0]     expected_o,
  output logic                 locked_o,
  output logic                 err_pulse_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [3:0]       LOCK_N = 4'(LOCK_MATCHES);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       expected_q, expected_d;
  logic [3:0]             streak_q, streak_d;
  logic                   locked_q, locked_d;
  logic                   err_pulse_q;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic                   mismatch;

  assign mismatch = en_i && (state_q == TRACK) && (count_in_i != expected_q);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    locked_d    = locked_q;
    err_count_d = err_count_q;

    // The prediction is refreshed on every edge so any state can reseed from it.
    if (load_i)                  expected_d = data_in_i;
    else if (count_in_i >= MAX_V) expected_d = '0;
    else                         expected_d = count_in_i + 1'b1;

    if (err_clr_i)                        err_count_d = '0;
    else if (mismatch && !(&err_count_q)) err_count_d = err_count_q + 1'b1;

    if (!en_i) begin
      state_d  = IDLE;
      streak_d = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: state_d = TRACK;
        TRACK: begin
          if (mismatch) begin
            state_d  = ACQUIRE;
            streak_d = '0;
            locked_d = 1'b0;
          end else begin
            streak_d = (streak_q == LOCK_N) ? streak_q : streak_q + 1'b1;
            locked_d = (streak_d == LOCK_N);
          end
        end
        default: begin
          state_d  = IDLE;
          streak_d = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      expected_q  <= '0;
      streak_q    <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      streak_q    <= streak_d;
      locked_q    <= locked_d;
      err_pulse_q <= mismatch;
      err_count_q <= err_count_d;
    end
  end

  assign expected_o  = expected_q;
  assign locked_o    = locked_q;
  assign err_pulse_o = err_pulse_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_counter_load_checker.sv
// tb/tb_counter_load_checker.sv - directed and randomized bench for counter_load_checker
// A behavioural counter drives count_in; a reference checker model predicts every output.
module tb_counter_load_checker;

  logic       clk_i = 1'b0;
  logic       rst_i, en_i, err_clr_i, load_i;
  logic [3:0] data_in_i, count_in_i;
  logic [3:0] expected_o, expected_s;
  logic       locked_o, locked_s, err_pulse_o, err_pulse_s;
  logic [7:0] err_count_o;
  logic [1:0] err_count_s;

  int n_checks = 0;
  int n_errors = 0;

  int cnt;
  int m_mode, m_streak, m_exp, m_locked, m_pulse, m_ec, m_ec2;

  always #5 clk_i = ~clk_i;

  counter_load_checker dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .err_clr_i(err_clr_i),
    .load_i(load_i), .data_in_i(data_in_i), .count_in_i(count_in_i),
    .expected_o(expected_o), .locked_o(locked_o),
    .err_pulse_o(err_pulse_o), .err_count_o(err_count_o)
  );

  counter_load_checker #(.ERR_CNT_W(2)) dut_s (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .err_clr_i(err_clr_i),
    .load_i(load_i), .data_in_i(data_in_i), .count_in_i(count_in_i),
    .expected_o(expected_s), .locked_o(locked_s),
    .err_pulse_o(err_pulse_s), .err_count_o(err_count_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_streak = 0; m_exp = 0; m_locked = 0; m_pulse = 0; m_ec = 0; m_ec2 = 0;
  endtask

  // Mode 0 = not checking, 1 = first enabled edge only seeds, 2 = comparing.
  task automatic model_edge();
    int cin;
    bit mism;
    cin  = int'(count_in_i);
    mism = en_i && (m_mode == 2) && (cin != m_exp);
    m_pulse = mism;
    if (err_clr_i) begin
      m_ec = 0; m_ec2 = 0;
    end else if (mism) begin
      m_ec  = (m_ec  < 255) ? m_ec + 1  : 255;
      m_ec2 = (m_ec2 < 3)   ? m_ec2 + 1 : 3;
    end
    if (load_i)      m_exp = int'(data_in_i);
    else if (cin >= 13) m_exp = 0;
    else             m_exp = (cin + 1) % 16;
    if (!en_i) begin
      m_mode = 0; m_streak = 0; m_locked = 0;
    end else if (m_mode < 2) begin
      m_mode = m_mode + 1;
    end else if (mism) begin
      m_mode = 1; m_streak = 0; m_locked = 0;
    end else begin
      m_streak = (m_streak < 2) ? m_streak + 1 : 2;
      m_locked = (m_streak == 2);
    end
  endtask

  task automatic check_all();
    chk("expected",    expected_o,  m_exp);
    chk("locked",      locked_o,    m_locked);
    chk("err_pulse",   err_pulse_o, m_pulse);
    chk("err_count",   err_count_o, m_ec);
    chk("err_count_s", err_count_s, m_ec2);
    chk("locked_s",    locked_s,    m_locked);
  endtask

  task automatic step(input bit ld, input logic [3:0] d, input bit en, input bit clr, input int frc);
    load_i = ld; data_in_i = d; en_i = en; err_clr_i = clr;
    @(posedge clk_i);
    model_edge();
    if (ld)             cnt = int'(d);
    else if (cnt >= 13) cnt = 0;
    else                cnt = cnt + 1;
    if (frc >= 0) cnt = frc;
    #1;
    count_in_i = 4'(cnt);
    check_all();
  endtask

  task automatic run_to(input int val);
    int k;
    k = 0;
    while (int'(count_in_i) != val && k < 20) begin
      step(1'b0, 4'd0, 1'b1, 1'b0, -1);
      k++;
    end
    chk("wait_for_count", (k < 20), 1);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 1'b0; err_clr_i = 1'b0; load_i = 1'b0;
    data_in_i = '0; count_in_i = '0; cnt = 0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_expected",  expected_o,  0);
    chk("rst_locked",    locked_o,    0);
    chk("rst_err_pulse", err_pulse_o, 0);
    chk("rst_err_count", err_count_o, 0);
    rst_i = 1'b0;

    // Lock: enable edge, seed edge, two matches.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, 1'b1, 1'b0, -1);
      chk("lock_latency", locked_o, (i == 3));
    end
    for (int i = 0; i < 50; i++) step(1'b0, 4'd0, 1'b1, 1'b0, -1);
    chk("wrap_no_error", err_count_o, 0);

    run_to(3);
    step(1'b1, 4'd7, 1'b1, 1'b0, -1);
    chk("load7_exp", expected_o, 7);
    step(1'b0, 4'd0, 1'b1, 1'b0, -1);
    chk("load7_next", expected_o, 8);
    chk("load7_pulse", err_pulse_o, 0);
    chk("load7_locked", locked_o, 1);

    step(1'b1, 4'd15, 1'b1, 1'b0, -1);
    chk("load15_exp", expected_o, 15);
    step(1'b0, 4'd0, 1'b1, 1'b0, -1);
    chk("load15_next", expected_o, 0);
    step(1'b0, 4'd0, 1'b1, 1'b0, -1);
    chk("load15_pulse", err_pulse_o, 0);
    chk("load15_count", err_count_o, 0);

    run_to(5);
    step(1'b0, 4'd0, 1'b1, 1'b0, 9);
    chk("skip_pre_pulse", err_pulse_o, 0);
    step(1'b0, 4'd0, 1'b1, 1'b0, -1);
    chk("skip_pulse", err_pulse_o, 1);
    chk("skip_count", err_count_o, 1);
    chk("skip_unlock", locked_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 1'b1, 1'b0, -1);
      chk("skip_pulse_once", err_pulse_o, 0);
      chk("relock", locked_o, (i == 2));
    end

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'd0, 1'b1, 1'b0, (int'(count_in_i) + 5) % 13);
      repeat (3) step(1'b0, 4'd0, 1'b1, 1'b0, -1);
    end
    chk("sat_count_s", err_count_s, 3);
    chk("sat_count", err_count_o, 6);
    step(1'b0, 4'd0, 1'b1, 1'b0, (int'(count_in_i) + 5) % 13);
    step(1'b0, 4'd0, 1'b1, 1'b1, -1);
    chk("clr_count", err_count_o, 0);
    chk("clr_count_s", err_count_s, 0);
    chk("clr_pulse", err_pulse_o, 1);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 15)) : -1);
    end

    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b1, 1'b0, -1);
    chk("pre_reset_locked", locked_o, 1);
    #3 rst_i = 1'b1;
    #1;
    model_reset();
    chk("async_expected",  expected_o,  0);
    chk("async_locked",    locked_o,    0);
    chk("async_err_pulse", err_pulse_o, 0);
    chk("async_err_count", err_count_o, 0);
    #2 rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd0, 1'b1, 1'b0, -1);
      chk("post_reset_lock", locked_o, (i == 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
